// File: rtl/hazard_stall_ctrl.sv
// Load-use / memory-wait hazard controller for the ID stage. Drives the PC and
// pipeline-register enables and flushes, and counts stalled cycles (saturating).
module hazard_stall_ctrl #(
  parameter int REG_W     = 5,
  parameter int LOAD_LAT  = 1,
  parameter int PERF_W    = 16,
  parameter int ZERO_SKIP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rt,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [5:0]        id_op,
  input  logic              id_branch_taken,
  input  logic              mem_access,
  input  logic              mem_ready,
  output logic              pc_write_en,
  output logic              ifid_write_en,
  output logic              ifid_flush,
  output logic              idex_write_en,
  output logic              idex_flush,
  output logic              exmem_write_en,
  output logic              memwb_flush,
  output logic              stall_busy,
  output logic [PERF_W-1:0] stall_count
);

  localparam int CW = $clog2(LOAD_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {IDLE, STALL} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PERF_W-1:0]  stall_count_q;
  logic               rt_used, hazard, mem_wait;

  // I-type ALU ops and loads write rt rather than read it
  always_comb begin
    case (id_op)
      6'b001000, 6'b001001, 6'b001010, 6'b001100,
      6'b001101, 6'b001110, 6'b001111, 6'b100011: rt_used = 1'b0;
      default:                                    rt_used = 1'b1;
    endcase
  end

  assign hazard = ex_mem_read
                & ((ex_rt == id_rs) | (rt_used & (ex_rt == id_rt)))
                & ~((ZERO_SKIP != 0) && (ex_rt == '0));
  assign mem_wait = mem_access & ~mem_ready;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_write_en    = 1'b1;
    ifid_write_en  = 1'b1;
    ifid_flush     = 1'b0;
    idex_write_en  = 1'b1;
    idex_flush     = 1'b0;
    exmem_write_en = 1'b1;
    memwb_flush    = 1'b0;
    stall_busy     = 1'b0;
    if (!rst_n) begin
      pc_write_en    = 1'b0;
      ifid_write_en  = 1'b0;
      idex_write_en  = 1'b0;
      exmem_write_en = 1'b0;
    end else if (mem_wait) begin
      // full freeze; FSM and bubble counter hold
      pc_write_en    = 1'b0;
      ifid_write_en  = 1'b0;
      idex_write_en  = 1'b0;
      exmem_write_en = 1'b0;
      memwb_flush    = 1'b1;
      stall_busy     = 1'b1;
    end else if (state_q == STALL || hazard) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_flush    = 1'b1;
      stall_busy    = 1'b1;
      if (state_q == STALL) begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = IDLE;
      end else if (LOAD_LAT > 1) begin
        state_d = STALL;
        cnt_d   = CNT_INIT;
      end
    end else if (id_branch_taken) begin
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_busy && stall_count_q != '1) stall_count_q <= stall_count_q + 1'b1;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: three instances (LOAD_LAT 1, LOAD_LAT 3,
// LOAD_LAT 3 with a 2-bit counter) share one stimulus set.
module tb_hazard_stall_ctrl;
  logic clk, rst_n;
  logic ex_mem_read, id_branch_taken, mem_access, mem_ready;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic [5:0] id_op;
  // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_flush, busy}
  logic [7:0] o1, o3, o2;
  logic [15:0] cnt1, cnt3;
  logic [1:0]  cnt2;
  int tests, fails;

  localparam logic [7:0] NORMAL = 8'hD4;
  localparam logic [7:0] BUBBLE = 8'h1D;
  localparam logic [7:0] FREEZE = 8'h03;
  localparam logic [7:0] BRANCH = 8'hF4;
  localparam logic [7:0] RSTOUT = 8'h00;

  hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(1), .PERF_W(16), .ZERO_SKIP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs),
    .id_rt(id_rt), .id_op(id_op), .id_branch_taken(id_branch_taken), .mem_access(mem_access),
    .mem_ready(mem_ready), .pc_write_en(o1[7]), .ifid_write_en(o1[6]), .ifid_flush(o1[5]),
    .idex_write_en(o1[4]), .idex_flush(o1[3]), .exmem_write_en(o1[2]), .memwb_flush(o1[1]),
    .stall_busy(o1[0]), .stall_count(cnt1));

  hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(3), .PERF_W(16), .ZERO_SKIP(1)) u3 (
    .clk(clk), .rst_n(rst_n), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs),
    .id_rt(id_rt), .id_op(id_op), .id_branch_taken(id_branch_taken), .mem_access(mem_access),
    .mem_ready(mem_ready), .pc_write_en(o3[7]), .ifid_write_en(o3[6]), .ifid_flush(o3[5]),
    .idex_write_en(o3[4]), .idex_flush(o3[3]), .exmem_write_en(o3[2]), .memwb_flush(o3[1]),
    .stall_busy(o3[0]), .stall_count(cnt3));

  hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(3), .PERF_W(2), .ZERO_SKIP(1)) u2 (
    .clk(clk), .rst_n(rst_n), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs),
    .id_rt(id_rt), .id_op(id_op), .id_branch_taken(id_branch_taken), .mem_access(mem_access),
    .mem_ready(mem_ready), .pc_write_en(o2[7]), .ifid_write_en(o2[6]), .ifid_flush(o2[5]),
    .idex_write_en(o2[4]), .idex_flush(o2[3]), .exmem_write_en(o2[2]), .memwb_flush(o2[1]),
    .stall_busy(o2[0]), .stall_count(cnt2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd4; id_rt = 5'd5; id_op = 6'b000000;
    id_branch_taken = 1'b0; mem_access = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    tests++;
    if (o1 !== RSTOUT || o3 !== RSTOUT || o2 !== RSTOUT) begin
      fails++; $display("FAIL reset_outputs: got %h/%h/%h want %h", o1, o3, o2, RSTOUT);
    end
    tests++;
    if (cnt1 !== 16'd0 || cnt3 !== 16'd0 || cnt2 !== 2'd0) begin
      fails++; $display("FAIL reset_count: got %0d/%0d/%0d want 0", cnt1, cnt3, cnt2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_no_hazard();
    idle_inputs();
    #1; tests++;
    if (o1 !== NORMAL) begin fails++; $display("FAIL no_hazard: got %h want %h", o1, NORMAL); end
    @(negedge clk);
    tests++;
    if (cnt1 !== 16'd0) begin fails++; $display("FAIL no_hazard_cnt: got %0d want 0", cnt1); end
  endtask

  task automatic test_load_use_lat1();
    id_rs = 5'd3;
    #1; tests++;
    if (o1 !== BUBBLE) begin fails++; $display("FAIL lu_rs_bubble: got %h want %h", o1, BUBBLE); end
    @(negedge clk);
    id_rs = 5'd4;
    #1; tests++;
    if (o1 !== NORMAL || cnt1 !== 16'd1) begin
      fails++; $display("FAIL lu_rs_after: got %h cnt %0d want %h cnt 1", o1, cnt1, NORMAL);
    end
    id_op = 6'b001110; id_rt = 5'd3;
    #1; tests++;
    if (o1 !== NORMAL) begin fails++; $display("FAIL lu_rt_unused: got %h want %h", o1, NORMAL); end
    id_op = 6'b000000;
    #1; tests++;
    if (o1 !== BUBBLE) begin fails++; $display("FAIL lu_rt_used: got %h want %h", o1, BUBBLE); end
    @(negedge clk);
    id_rt = 5'd5;
    #1; tests++;
    if (cnt1 !== 16'd2) begin fails++; $display("FAIL lu_cnt: got %0d want 2", cnt1); end
  endtask

  task automatic test_lat3();
    logic [7:0] exp3 [0:3];
    exp3[0] = BUBBLE; exp3[1] = BUBBLE; exp3[2] = BUBBLE; exp3[3] = NORMAL;
    do_reset();
    id_rs = 5'd3;
    for (int i = 0; i < 4; i++) begin
      #1; tests++;
      if (o3 !== exp3[i]) begin fails++; $display("FAIL lat3_cyc%0d: got %h want %h", i, o3, exp3[i]); end
      @(negedge clk);
      id_rs = 5'd4;
    end
    tests++;
    if (cnt3 !== 16'd3) begin fails++; $display("FAIL lat3_cnt: got %0d want 3", cnt3); end
    ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1; tests++;
    if (o3 !== NORMAL || o1 !== NORMAL) begin
      fails++; $display("FAIL zero_skip: got %h/%h want %h", o1, o3, NORMAL);
    end
    @(negedge clk);
    tests++;
    if (cnt3 !== 16'd3) begin fails++; $display("FAIL zero_skip_cnt: got %0d want 3", cnt3); end
  endtask

  task automatic test_mem_wait();
    logic [7:0] expw [0:5];
    logic       rdy  [0:5];
    expw[0] = BUBBLE; expw[1] = FREEZE; expw[2] = FREEZE;
    expw[3] = BUBBLE; expw[4] = BUBBLE; expw[5] = NORMAL;
    rdy[0] = 1'b1; rdy[1] = 1'b0; rdy[2] = 1'b0; rdy[3] = 1'b1; rdy[4] = 1'b1; rdy[5] = 1'b1;
    do_reset();
    id_rs = 5'd3;
    for (int i = 0; i < 6; i++) begin
      mem_access = (i > 0); mem_ready = rdy[i];
      #1; tests++;
      if (o3 !== expw[i]) begin fails++; $display("FAIL memwait_cyc%0d: got %h want %h", i, o3, expw[i]); end
      @(negedge clk);
      id_rs = 5'd4;
    end
    mem_access = 1'b0;
    tests++;
    if (cnt3 !== 16'd5) begin fails++; $display("FAIL memwait_cnt: got %0d want 5", cnt3); end
  endtask

  task automatic test_branch();
    do_reset();
    id_rs = 5'd3; id_branch_taken = 1'b1;
    #1; tests++;
    if (o1 !== BUBBLE) begin fails++; $display("FAIL branch_hazard: got %h want %h", o1, BUBBLE); end
    @(negedge clk);
    id_rs = 5'd4;
    #1; tests++;
    if (o1 !== BRANCH) begin fails++; $display("FAIL branch_flush: got %h want %h", o1, BRANCH); end
    @(negedge clk);
    id_branch_taken = 1'b0;
  endtask

  task automatic test_saturate_reset();
    do_reset();
    id_rs = 5'd3;
    repeat (2) @(negedge clk);
    tests++;
    if (cnt2 !== 2'd2) begin fails++; $display("FAIL sat_cnt2: got %0d want 2", cnt2); end
    repeat (3) @(negedge clk);
    tests++;
    if (cnt2 !== 2'd3 || cnt3 !== 16'd5) begin
      fails++; $display("FAIL sat_hold: got %0d/%0d want 3/5", cnt2, cnt3);
    end
    id_rs = 5'd4;
    #1; tests++;
    if (o2 !== BUBBLE) begin fails++; $display("FAIL mid_stall: got %h want %h", o2, BUBBLE); end
    rst_n = 1'b0;
    #1; tests++;
    if (o2 !== RSTOUT || cnt2 !== 2'd0) begin
      fails++; $display("FAIL async_reset: got %h cnt %0d want %h cnt 0", o2, cnt2, RSTOUT);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1; tests++;
    if (o2 !== NORMAL) begin fails++; $display("FAIL post_reset_idle: got %h want %h", o2, NORMAL); end
    @(negedge clk);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_no_hazard();
    test_load_use_lat1();
    test_lat3();
    test_mem_wait();
    test_branch();
    test_saturate_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Parametrised load-use and memory-wait hazard controller for the pipelined MIPS core; sits beside the ID stage and drives the PC and pipeline-register enable and flush lines. It extends single-bubble load-use detection in three ways: a configurable multi-cycle load latency handled by a stall counter, whole-pipe freeze on a data-memory wait handshake, and taken-branch IF/ID flush. It also provides a saturating stall-cycle performance counter.

Parameters:
REG_W, 5, register-specifier width
LOAD_LAT, 1, bubble cycles per load-use hazard (1..15)
PERF_W, 16, width of stall performance counter
ZERO_SKIP, 1, 1 = register 0 never causes a hazard

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_mem_read  in  1  instruction in EX is a load
ex_rt  in  REG_W  destination of EX load
id_rs  in  REG_W  ID source rs
id_rt  in  REG_W  ID source rt
id_op  in  6  ID opcode
id_branch_taken  in  1  branch/jump resolved taken in ID
mem_access  in  1  MEM stage performing a load/store
mem_ready  in  1  data memory ready
pc_write_en  out  1  PC update enable
ifid_write_en  out  1  IF/ID register enable
ifid_flush  out  1  clear IF/ID (wrong-path fetch)
idex_write_en  out  1  ID/EX register enable
idex_flush  out  1  insert bubble into ID/EX
exmem_write_en  out  1  EX/MEM register enable
memwb_flush  out  1  insert bubble into MEM/WB
stall_busy  out  1  any stall/freeze active this cycle
stall_count  out  PERF_W  saturating count of stalled cycles

Behaviour:
- rt_used = 0 for id_op in {001000,001001,001010,001100,001101,001110,001111,100011}; 1 otherwise.
- hazard = ex_mem_read & ((ex_rt==id_rs) | (rt_used & ex_rt==id_rt)) & ~(ZERO_SKIP & ex_rt==0). Combinational, same cycle.
- mem_wait = mem_access & ~mem_ready.
- FSM states: IDLE, STALL (cnt = remaining bubbles, width clog2(LOAD_LAT+1)).
- Priority per cycle: mem_wait > load-use (hazard in IDLE, or state STALL) > branch flush > normal.
- mem_wait: pc/ifid/idex/exmem_write_en=0, memwb_flush=1, idex_flush=0, ifid_flush=0; FSM and cnt hold.
- Load-use bubble (IDLE & hazard, or STALL): pc_write_en=0, ifid_write_en=0, idex_flush=1, idex_write_en=1, exmem_write_en=1, ifid_flush=0; id_branch_taken ignored (branch re-resolves after stall).
- IDLE & hazard & ~mem_wait: if LOAD_LAT>1, go STALL with cnt=LOAD_LAT-1; else stay IDLE. Exactly LOAD_LAT bubble cycles total.
- STALL & ~mem_wait: cnt decrements; cnt==1 -> IDLE next cycle. New hazard is not evaluated in STALL.
- Branch (no stall, no wait, id_branch_taken): ifid_flush=1, all write_en=1.
- Normal: all write_en=1, all flushes=0.
- stall_busy = mem_wait | bubble cycle. stall_count +1 per stall_busy cycle, saturates at all-ones, no wrap.
- Reset (rst_n=0, async, including mid-STALL): state IDLE, cnt=0, stall_count=0; outputs forced to all write_en=0, all flushes=0, stall_busy=0. On release, first evaluation uses live inputs.
- The only registered state is the FSM, cnt and stall_count. All enables and flushes are combinational from inputs and state.

Test Plan:
- No hazard: ex_mem_read=1, ex_rt=3, id_rs=4, id_rt=5, id_op=000000 -> all write_en=1, flushes=0, stall_count stays 0.
- Load-use rs, LOAD_LAT=1: ex_rt=3=id_rs -> 1 cycle pc/ifid_write_en=0, idex_flush=1, stall_count=1. Repeat with id_op=001110, id_rt=3, id_rs=4 -> no stall.
- LOAD_LAT=3: hazard pulse for one cycle only -> exactly 3 consecutive bubble cycles, then IDLE; ex_rt=0 with ZERO_SKIP=1 -> no stall.
- mem_wait during STALL: LOAD_LAT=3, mem_ready=0 for 2 cycles in bubble 2 -> full freeze (memwb_flush=1, exmem_write_en=0) for 2 cycles, then bubbles 2 and 3 resume. Total busy cycles = 5.
- Branch vs hazard: id_branch_taken=1 with hazard -> bubble only, ifid_flush=0. Next cycle branch still taken, no hazard -> ifid_flush=1.
- Async reset mid-STALL, and PERF_W=2 saturation: counter holds at 3 after 5 stall cycles; rst_n low -> outputs 0 immediately, stall_count=0, IDLE.
